// File: rtl/conv_mac_sequencer.sv
// Window sequencer for the signed 8-bit MAC: issues pixel/weight reads, gates operands, latches the sum.
// Optional CONV_SEQ_RELU_EN: clamp negative window sums to zero at capture.
module conv_mac_sequencer #(
    parameter int KSIZE   = 3,
    parameter int IMG_W   = 16,
    parameter int ADDR_W  = 8,
    parameter int ACC_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base,
    output logic              Busy,
    output logic [ADDR_W-1:0] PixAddr,
    output logic [3:0]        WgtAddr,
    input  logic [7:0]        PixData,
    input  logic [7:0]        WgtData,
    output logic [7:0]        MacX,
    output logic [7:0]        MacY,
    output logic              AccumReset,
    input  logic [31:0]       AccIn,
    output logic [31:0]       Result,
    output logic              ResultValid,
    input  logic              ResultReady
);
    localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int LW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
    localparam logic [ADDR_W-1:0] Pitch = ADDR_W'(IMG_W);
    localparam logic [KW-1:0] LastIdx = KW'(KSIZE - 1);
    localparam logic [LW-1:0] LastLat = LW'(ACC_LAT - 1);

    typedef enum logic [2:0] {Idle, Clear, Fetch, Drain, Done} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rowBase;
    logic [KW-1:0]     row;
    logic [KW-1:0]     col;
    logic [LW-1:0]     drainCnt;
    logic              tapVld;
    logic [31:0]       capVal;

`ifdef CONV_SEQ_RELU_EN
    assign capVal = AccIn[31] ? 32'd0 : AccIn;
`else
    assign capVal = AccIn;
`endif

    assign Busy        = (state != Idle);
    assign AccumReset  = (state == Clear);
    assign ResultValid = (state == Done);
    assign MacX        = tapVld ? PixData : 8'd0;
    assign MacY        = tapVld ? WgtData : 8'd0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= Idle;
            rowBase  <= '0;
            row      <= '0;
            col      <= '0;
            drainCnt <= '0;
            tapVld   <= 1'b0;
            PixAddr  <= '0;
            WgtAddr  <= '0;
            Result   <= '0;
        end else begin
            // Memory read latency is one cycle, so operands trail the address by one.
            tapVld <= (state == Fetch);
            unique case (state)
                Idle: begin
                    if (Start) begin
                        rowBase <= Base;
                        row     <= '0;
                        col     <= '0;
                        state   <= Clear;
                    end
                end
                Clear: begin
                    PixAddr <= rowBase;
                    WgtAddr <= '0;
                    row     <= '0;
                    col     <= '0;
                    state   <= Fetch;
                end
                Fetch: begin
                    if (row == LastIdx && col == LastIdx) begin
                        drainCnt <= '0;
                        state    <= Drain;
                    end else begin
                        WgtAddr <= WgtAddr + 4'd1;
                        if (col == LastIdx) begin
                            col     <= '0;
                            row     <= row + KW'(1);
                            rowBase <= rowBase + Pitch;
                            PixAddr <= rowBase + Pitch;
                        end else begin
                            col     <= col + KW'(1);
                            PixAddr <= PixAddr + ADDR_W'(1);
                        end
                    end
                end
                Drain: begin
                    if (drainCnt == LastLat) begin
                        Result <= capVal;
                        state  <= Done;
                    end else begin
                        drainCnt <= drainCnt + LW'(1);
                    end
                end
                Done: begin
                    if (ResultReady) state <= Idle;
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule

// File: doc/conv_mac_sequencer.md
# conv_mac_sequencer

Sequencer for the 8-bit signed multiply-accumulate datapath in the convolution engine. On each Start it clears the accumulator, then walks a KSIZE×KSIZE window. For each tap it issues one pixel address and one weight address to synchronous-read memories, and steers the returned operands into the MAC. Once the pipeline has drained it latches the 32-bit accumulator value and offers it on a valid/ready result port.

## Interface
Parameters:
- KSIZE, 3, kernel edge length; TAPS = KSIZE*KSIZE (legal 1..15)
- IMG_W, 16, image row pitch in pixels
- ADDR_W, 8, pixel address width
- ACC_LAT, 2, cycles from last tap address issue to accumulator output valid (1 memory + 1 accumulator register)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin one window; sampled only in IDLE
- Base  in  ADDR_W  pixel address of window top-left; sampled with Start
- Busy  out  1  high whenever state ≠ IDLE
- PixAddr  out  ADDR_W  pixel memory read address
- WgtAddr  out  4  weight memory read address (tap index)
- PixData  in  8  signed pixel, valid 1 cycle after PixAddr
- WgtData  in  8  signed weight, valid 1 cycle after WgtAddr
- MacX  out  8  MAC operand x
- MacY  out  8  MAC operand y
- AccumReset  out  1  synchronous clear to accumulator
- AccIn  in  32  accumulator LocalReg
- Result  out  32  latched signed window sum
- ResultValid  out  1  Result available
- ResultReady  in  1  consumer accepts Result

## Operation
- States: IDLE, CLEAR, FETCH, DRAIN, DONE.
- IDLE → CLEAR when Start=1. Latch Base, zero the tap counters (r, c).
- CLEAR: AccumReset=1 for exactly one cycle. Next state is FETCH.
- FETCH: one tap per cycle, row-major.
  - PixAddr = Base + r*IMG_W + c, modulo 2^ADDR_W. Wrap-around is silent.
  - WgtAddr = r*KSIZE + c.
  - Row base is kept incrementally, with no multiplier.
  - After tap TAPS-1 the next state is DRAIN.
- Operand gating: TapVld is FETCH delayed one cycle. MacX = TapVld ? PixData : 0 and MacY = TapVld ? WgtData : 0, combinational from that register. The always-accumulating MAC therefore adds 0 on idle cycles.
- DRAIN: counts ACC_LAT cycles. On its final edge it captures AccIn (optionally rectified) into Result, and the next state is DONE.
- DONE: ResultValid=1. Result holds stable until ResultReady=1, then the next state is IDLE. Start is ignored in DONE.
- Start is ignored in every state other than IDLE. Base is not re-sampled.
- Reset (async, any state): state=IDLE, counters=0, Busy=0, AccumReset=0, PixAddr=0, WgtAddr=0, TapVld=0 (so MacX=MacY=0), Result=0, ResultValid=0. An in-flight window is discarded, and the next Start re-clears the accumulator.

## Timing
- Start sampled at edge E0.
  - CLEAR holds after E0.
  - FETCH runs for taps 0..TAPS-1, after edges E1..E(TAPS).
  - DRAIN runs after E(TAPS+1)..E(TAPS+ACC_LAT).
  - Result is captured and ResultValid rises at E(TAPS+ACC_LAT+1). With defaults this is E12.
- ResultValid&ResultReady at edge En returns the block to IDLE after En. The earliest next Start is sampled at E(n+1), so there is one bubble cycle.
- Throughput: one window per TAPS+ACC_LAT+3 cycles with ResultReady tied high.
- The accumulator clears at E1. The first nonzero MAC operands appear after E2.

## Configuration
- CONV_SEQ_RELU_EN defined: capture Result = AccIn[31] ? 0 : AccIn (ReLU).
- Undefined: Result = AccIn unmodified (signed two's complement).
- Timing is identical in both builds.

## Test plan
- Reset check: assert Reset mid-stream → all outputs 0 immediately (asynchronously), state IDLE, and no ResultValid afterwards. Then Start with Base=0 → normal result.
- All ones: pixels and weights all 1, Base=0x10, Start at E0 → ResultValid rises at E12 with Result=9. PixAddr sequence is 0x10,0x11,0x12,0x20,0x21,0x22,0x30,0x31,0x32.
- Signed extreme: pixels all -128, weights all 127 → Result=0xFFFDC480 (-146304) without the macro, and 0 with CONV_SEQ_RELU_EN.
- Backpressure: ResultReady=0 for 5 cycles after ResultValid → Result and ResultValid held stable, and a Start pulse during DONE is ignored. Raise ResultReady → IDLE on the next edge, Busy=0.
- Address wrap: Base=0xEF, IMG_W=16 → PixAddr sequence 0xEF,0xF0,0xF1,0xFF,0x00,0x01,0x0F,0x10,0x11.
- Reset mid-FETCH at tap 4, then a new Start with all-ones data → Result=9, with no residue from the aborted window.
